sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO; successor to the fixed 8-bit put/get FIFO.

---
 rtl/sync_fifo_param_pkg.sv | 23 ++
 rtl/sync_fifo_param_if.sv | 31 +++
 rtl/sync_fifo_param_mem.sv | 25 ++
 rtl/sync_fifo_param.sv | 112 +++++++++++
 tb/tb_sync_fifo_param.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_param_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package sync_fifo_param_pkg;

  // Read-mode selectors for the FWFT parameter
  localparam int MODE_REG  = 0;  // data_out registered, one cycle after get
  localparam int MODE_FWFT = 1;  // head word shown ahead of get

  // Ceiling log2; constant-foldable so it can size ports and localparams
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Pointer width for a given depth (at least one bit)
  function automatic int addr_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Request/response bundle between a FIFO user (master) and the FIFO (slave).
interface sync_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int AW = sync_fifo_param_pkg::addr_width(DEPTH);

  logic             flush;
  logic             clr_err;
  logic [WIDTH-1:0] data_in;
  logic             put;
  logic             get;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, clr_err, data_in, put, get,
    input  data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, data_in, put, get,
    output data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param_mem.sv
// Dual-port storage: one synchronous write port, one asynchronous read port.
module sync_fifo_param_mem
  import sync_fifo_param_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [addr_width(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic [addr_width(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]            rd_data
);
  logic [WIDTH-1:0] mem_reg [DEPTH];

  // Write port; contents are never reset, only overwritten
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_reg[rd_addr];
endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with thresholds, occupancy, sticky errors, flush and
// selectable registered / show-ahead read.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 4,
  parameter int AFULL_THRESH  = 3,
  parameter int AEMPTY_THRESH = 1,
  parameter int FWFT          = MODE_REG
) (
  input logic              clk,
  input logic              reset,
  sync_fifo_param_if.slave bus
);
  localparam int          AW        = addr_width(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AF_CNT    = (AW + 1)'(AFULL_THRESH);
  localparam logic [AW:0] AE_CNT    = (AW + 1)'(AEMPTY_THRESH);

  // Refuse to build with an unusable geometry or threshold
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      AFULL_THRESH < 1 || AFULL_THRESH > DEPTH ||
      AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1 ||
      (FWFT != MODE_REG && FWFT != MODE_FWFT)) begin : g_bad_params
    $fatal(1, "sync_fifo_param: illegal DEPTH/threshold/FWFT parameters");
  end

  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg, count_next;
  logic             overflow_reg, underflow_reg;
  logic             empty_w, full_w;
  logic             get_ok, put_ok, ovf_evt, unf_evt;
  logic [WIDTH-1:0] rd_data;

  assign empty_w = (count_reg == '0);
  assign full_w  = (count_reg == DEPTH_CNT);

  // Accept decisions and error events, all from pre-edge state
  always_comb begin
    get_ok  = bus.get & ~empty_w;
    put_ok  = bus.put & (~full_w | get_ok);
    ovf_evt = bus.put & ~put_ok;
    unf_evt = bus.get & empty_w;
    case ({put_ok, get_ok})
      2'b10:   count_next = count_reg + (AW + 1)'(1);
      2'b01:   count_next = count_reg - (AW + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers and occupancy; flush drops this cycle's put/get
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (put_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (get_ok) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  // Sticky error flags; a fresh error beats clr_err, flush leaves them alone
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (!bus.flush) begin
      overflow_reg  <= (overflow_reg  & ~bus.clr_err) | ovf_evt;
      underflow_reg <= (underflow_reg & ~bus.clr_err) | unf_evt;
    end
  end

  sync_fifo_param_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (put_ok & ~bus.flush & ~reset),
    .wr_addr (wr_ptr_reg),
    .wr_data (bus.data_in),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_data)
  );

  if (FWFT == MODE_FWFT) begin : g_fwft
    assign bus.data_out = empty_w ? '0 : rd_data;
  end else begin : g_reg
    logic [WIDTH-1:0] data_out_reg;

    // Registered read: capture the head word only when a get is accepted
    always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
        data_out_reg <= '0;
      end else if (get_ok) begin
        data_out_reg <= rd_data;
      end
    end

    assign bus.data_out = data_out_reg;
  end

  assign bus.empty        = empty_w;
  assign bus.full         = full_w;
  assign bus.almost_empty = (count_reg <= AE_CNT);
  assign bus.almost_full  = (count_reg >= AF_CNT);
  assign bus.count        = count_reg;
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: drives a registered-read and a show-ahead FIFO in lockstep.
module tb_sync_fifo_param;
  logic       clk = 1'b0;
  logic       reset = 1'b0, flush = 1'b0, clr_err = 1'b0, put = 1'b0, get = 1'b0;
  logic [7:0] data_in = 8'h00;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(8), .DEPTH(4)) if_r ();
  sync_fifo_param_if #(.WIDTH(8), .DEPTH(4)) if_f ();

  assign if_r.flush = flush;   assign if_f.flush = flush;
  assign if_r.clr_err = clr_err; assign if_f.clr_err = clr_err;
  assign if_r.data_in = data_in; assign if_f.data_in = data_in;
  assign if_r.put = put;       assign if_f.put = put;
  assign if_r.get = get;       assign if_f.get = get;

  sync_fifo_param #(.WIDTH(8), .DEPTH(4), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(0))
    dut_r (.clk(clk), .reset(reset), .bus(if_r));
  sync_fifo_param #(.WIDTH(8), .DEPTH(4), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(1))
    dut_f (.clk(clk), .reset(reset), .bus(if_f));

  // {count[2:0], empty, full, almost_empty, almost_full, overflow, underflow}
  logic [8:0] st_r, st_f;
  assign st_r = {if_r.count, if_r.empty, if_r.full, if_r.almost_empty, if_r.almost_full,
                 if_r.overflow, if_r.underflow};
  assign st_f = {if_f.count, if_f.empty, if_f.full, if_f.almost_empty, if_f.almost_full,
                 if_f.overflow, if_f.underflow};

  // Expected status for DEPTH=4, AFULL=3, AEMPTY=1
  function automatic logic [8:0] exp_st(input int cnt, input logic ovf, input logic unf);
    return {3'(cnt), cnt == 0, cnt == 4, cnt <= 1, cnt >= 3, ovf, unf};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [8:0] e;
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    e = exp_st(0, 1'b0, 1'b0);
    checks++;
    if ({st_r, st_f} !== {e, e}) begin
      failures++; $display("FAIL reset_status got r=%h f=%h exp=%h", st_r, st_f, e);
    end
    checks++;
    if ({if_r.data_out, if_f.data_out} !== 16'h0000) begin
      failures++; $display("FAIL reset_data got r=%h f=%h exp=00", if_r.data_out, if_f.data_out);
    end
    $display("reset: status r=%h f=%h", st_r, st_f);
  endtask

  task automatic test_fill_drain;
    logic [7:0] v [4];
    logic [8:0] e;
    v = '{8'hFF, 8'h00, 8'hAA, 8'h55};
    for (int i = 0; i < 4; i++) begin
      put = 1'b1; data_in = v[i]; tick(); put = 1'b0;
      e = exp_st(i + 1, 1'b0, 1'b0);
      checks++;
      if ({st_r, st_f} !== {e, e}) begin
        failures++; $display("FAIL fill_status[%0d] got r=%h f=%h exp=%h", i, st_r, st_f, e);
      end
      $display("fill put %h: count=%0d", v[i], if_r.count);
    end
    put = 1'b1; data_in = 8'h11; tick(); put = 1'b0;
    e = exp_st(4, 1'b1, 1'b0);
    checks++;
    if ({st_r, st_f} !== {e, e}) begin
      failures++; $display("FAIL overflow_status got r=%h f=%h exp=%h", st_r, st_f, e);
    end
    $display("fill put 11 on full: overflow=%b", if_r.overflow);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (if_f.data_out !== v[i]) begin
        failures++; $display("FAIL drain_fwft[%0d] got %h exp %h", i, if_f.data_out, v[i]);
      end
      get = 1'b1; tick(); get = 1'b0;
      e = exp_st(3 - i, 1'b1, 1'b0);
      checks++;
      if ({st_r, st_f} !== {e, e}) begin
        failures++; $display("FAIL drain_status[%0d] got r=%h f=%h exp=%h", i, st_r, st_f, e);
      end
      checks++;
      if (if_r.data_out !== v[i]) begin
        failures++; $display("FAIL drain_reg[%0d] got %h exp %h", i, if_r.data_out, v[i]);
      end
      $display("drain get: r=%h count=%0d", if_r.data_out, if_r.count);
    end
    checks++;
    if (if_f.data_out !== 8'h00) begin
      failures++; $display("FAIL empty_fwft got %h exp 00", if_f.data_out);
    end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    e = exp_st(0, 1'b0, 1'b0);
    checks++;
    if ({st_r, st_f} !== {e, e}) begin
      failures++; $display("FAIL clr_overflow got r=%h f=%h exp=%h", st_r, st_f, e);
    end
    $display("clr_err: overflow=%b", if_r.overflow);
  endtask

  task automatic test_full_put_get;
    logic [7:0] v [4];
    logic [7:0] rest [4];
    logic [8:0] e;
    v = '{8'hFF, 8'h00, 8'hAA, 8'h55};
    rest = '{8'h00, 8'hAA, 8'h55, 8'h77};
    for (int i = 0; i < 4; i++) begin
      put = 1'b1; data_in = v[i]; tick();
    end
    put = 1'b0;
    checks++;
    if (if_f.data_out !== 8'hFF) begin
      failures++; $display("FAIL full_head_fwft got %h exp FF", if_f.data_out);
    end
    put = 1'b1; get = 1'b1; data_in = 8'h77; tick(); put = 1'b0; get = 1'b0;
    e = exp_st(4, 1'b0, 1'b0);
    checks++;
    if ({st_r, st_f} !== {e, e}) begin
      failures++; $display("FAIL full_putget_status got r=%h f=%h exp=%h", st_r, st_f, e);
    end
    checks++;
    if (if_r.data_out !== 8'hFF) begin
      failures++; $display("FAIL full_putget_reg got %h exp FF", if_r.data_out);
    end
    $display("full put 77 + get: r=%h count=%0d", if_r.data_out, if_r.count);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (if_f.data_out !== rest[i]) begin
        failures++; $display("FAIL order_fwft[%0d] got %h exp %h", i, if_f.data_out, rest[i]);
      end
      get = 1'b1; tick(); get = 1'b0;
      checks++;
      if (if_r.data_out !== rest[i]) begin
        failures++; $display("FAIL order_reg[%0d] got %h exp %h", i, if_r.data_out, rest[i]);
      end
      $display("order get: r=%h", if_r.data_out);
    end
    e = exp_st(0, 1'b0, 1'b0);
    checks++;
    if ({st_r, st_f} !== {e, e}) begin
      failures++; $display("FAIL order_end_status got r=%h f=%h exp=%h", st_r, st_f, e);
    end
  endtask

  task automatic test_underflow;
    logic [8:0] e;
    get = 1'b1; tick(); get = 1'b0;
    e = exp_st(0, 1'b0, 1'b1);
    checks++;
    if ({st_r, st_f} !== {e, e}) begin
      failures++; $display("FAIL underflow_status got r=%h f=%h exp=%h", st_r, st_f, e);
    end
    checks++;
    if ({if_r.data_out, if_f.data_out} !== {8'h77, 8'h00}) begin
      failures++; $display("FAIL underflow_data got r=%h f=%h exp r=77 f=00", if_r.data_out, if_f.data_out);
    end
    $display("get on empty: underflow=%b r=%h", if_r.underflow, if_r.data_out);
    put = 1'b1; get = 1'b1; data_in = 8'h33; tick(); put = 1'b0; get = 1'b0;
    e = exp_st(1, 1'b0, 1'b1);
    checks++;
    if ({st_r, st_f} !== {e, e}) begin
      failures++; $display("FAIL empty_putget_status got r=%h f=%h exp=%h", st_r, st_f, e);
    end
    checks++;
    if ({if_r.data_out, if_f.data_out} !== {8'h77, 8'h33}) begin
      failures++; $display("FAIL empty_putget_data got r=%h f=%h exp r=77 f=33", if_r.data_out, if_f.data_out);
    end
    $display("empty put 33 + get: count=%0d", if_r.count);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    e = exp_st(1, 1'b0, 1'b0);
    checks++;
    if ({st_r, st_f} !== {e, e}) begin
      failures++; $display("FAIL clr_underflow got r=%h f=%h exp=%h", st_r, st_f, e);
    end
    get = 1'b1; tick(); get = 1'b0;
    checks++;
    if (if_r.data_out !== 8'h33) begin
      failures++; $display("FAIL read_33_reg got %h exp 33", if_r.data_out);
    end
    clr_err = 1'b1; get = 1'b1; tick(); clr_err = 1'b0; get = 1'b0;
    e = exp_st(0, 1'b0, 1'b1);
    checks++;
    if ({st_r, st_f} !== {e, e}) begin
      failures++; $display("FAIL clr_vs_new_err got r=%h f=%h exp=%h", st_r, st_f, e);
    end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    $display("clr_err with new underflow: underflow=%b", if_r.underflow);
  endtask

  task automatic test_back_to_back;
    logic [8:0] e;
    put = 1'b1; data_in = 8'd0; tick(); data_in = 8'd1; tick(); put = 1'b0;
    e = exp_st(2, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (if_f.data_out !== 8'(i)) begin
        failures++; $display("FAIL b2b_fwft[%0d] got %h exp %h", i, if_f.data_out, 8'(i));
      end
      put = 1'b1; get = 1'b1; data_in = 8'(i + 2); tick(); put = 1'b0; get = 1'b0;
      checks++;
      if ({st_r, st_f} !== {e, e}) begin
        failures++; $display("FAIL b2b_status[%0d] got r=%h f=%h exp=%h", i, st_r, st_f, e);
      end
      checks++;
      if (if_r.data_out !== 8'(i)) begin
        failures++; $display("FAIL b2b_reg[%0d] got %h exp %h", i, if_r.data_out, 8'(i));
      end
      $display("b2b %0d: put %0d got %0d count=%0d", i, i + 2, if_r.data_out, if_r.count);
    end
    for (int i = 20; i < 22; i++) begin
      get = 1'b1; tick(); get = 1'b0;
      checks++;
      if (if_r.data_out !== 8'(i)) begin
        failures++; $display("FAIL b2b_tail[%0d] got %h exp %h", i, if_r.data_out, 8'(i));
      end
    end
  endtask

  task automatic test_flush;
    logic [8:0] e;
    get = 1'b1; tick(); get = 1'b0;  // leave underflow set across the flush
    put = 1'b1;
    data_in = 8'hA1; tick(); data_in = 8'hA2; tick(); data_in = 8'hA3; tick();
    put = 1'b0;
    e = exp_st(3, 1'b0, 1'b1);
    checks++;
    if ({st_r, st_f} !== {e, e}) begin
      failures++; $display("FAIL preflush_status got r=%h f=%h exp=%h", st_r, st_f, e);
    end
    flush = 1'b1; put = 1'b1; data_in = 8'hEE; tick(); flush = 1'b0; put = 1'b0;
    e = exp_st(0, 1'b0, 1'b1);
    checks++;
    if ({st_r, st_f} !== {e, e}) begin
      failures++; $display("FAIL flush_status got r=%h f=%h exp=%h", st_r, st_f, e);
    end
    checks++;
    if ({if_r.data_out, if_f.data_out} !== 16'h0000) begin
      failures++; $display("FAIL flush_data got r=%h f=%h exp=00", if_r.data_out, if_f.data_out);
    end
    $display("flush with put: count=%0d r=%h f=%h", if_r.count, if_r.data_out, if_f.data_out);
    put = 1'b1; data_in = 8'h44; tick(); put = 1'b0;
    checks++;
    if (if_f.data_out !== 8'h44) begin
      failures++; $display("FAIL postflush_fwft got %h exp 44", if_f.data_out);
    end
    get = 1'b1; tick(); get = 1'b0;
    checks++;
    if (if_r.data_out !== 8'h44) begin
      failures++; $display("FAIL postflush_reg got %h exp 44", if_r.data_out);
    end
  endtask

  task automatic test_reset_mid_fill;
    logic [8:0] e;
    put = 1'b1; data_in = 8'hB1; tick(); data_in = 8'hB2; tick();
    reset = 1'b1; data_in = 8'hB3; tick(); reset = 1'b0; put = 1'b0;
    e = exp_st(0, 1'b0, 1'b0);
    checks++;
    if ({st_r, st_f} !== {e, e}) begin
      failures++; $display("FAIL midreset_status got r=%h f=%h exp=%h", st_r, st_f, e);
    end
    checks++;
    if ({if_r.data_out, if_f.data_out} !== 16'h0000) begin
      failures++; $display("FAIL midreset_data got r=%h f=%h exp=00", if_r.data_out, if_f.data_out);
    end
    $display("reset mid-fill: count=%0d underflow=%b", if_r.count, if_r.underflow);
  endtask

  initial begin
    tick();
    test_reset();
    test_fill_drain();
    test_full_put_get();
    test_underflow();
    test_back_to_back();
    test_flush();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
